overlap_seq_ctrl: RTL and testbench

OVERLAP_SEQ_CTRL -- requirements
Module: overlap_seq_ctrl

---
 rtl/overlap_pkg.sv | 24 ++
 rtl/overlap_seq_ctrl_if.sv | 26 ++
 rtl/overlap_tag_pipe.sv | 52 +++++
 rtl/overlap_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_overlap_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/overlap_pkg.sv
// Shared state encoding and sizing helpers for the overlap-add row sequencer.
package overlap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN
  } state_e;

  function automatic int out_len(input int input_width, input int kernel_width, input int stride);
    return (input_width - 1) * stride + kernel_width;
  endfunction

  // ceil((K-S)/S) reduces to floor((K-1)/S), which is also 0 whenever K <= S
  function automatic int flush_groups(input int kernel_width, input int stride);
    return (kernel_width - 1) / stride;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/overlap_seq_ctrl_if.sv
// Partial-product input, overlap-buffer port and output row stream of the sequencer.
interface overlap_seq_ctrl_if #(
  parameter int BIT_WIDTH = 8
);

  logic                 s_valid_i;
  logic                 s_ready_o;
  logic [BIT_WIDTH-1:0] s_data_i;
  logic                 buf_wr_en_o;
  logic [BIT_WIDTH-1:0] buf_data_o;
  logic [BIT_WIDTH-1:0] buf_data_i;
  logic                 m_valid_o;
  logic [BIT_WIDTH-1:0] m_data_o;
  logic                 m_last_o;

  modport master (
    input  s_valid_i, s_data_i, buf_data_i,
    output s_ready_o, buf_wr_en_o, buf_data_o, m_valid_o, m_data_o, m_last_o
  );

  modport slave (
    output s_valid_i, s_data_i, buf_data_i,
    input  s_ready_o, buf_wr_en_o, buf_data_o, m_valid_o, m_data_o, m_last_o
  );

endinterface

// File: rtl/overlap_tag_pipe.sv
// Three-stage delay line aligning emit tags with the overlap buffer read-back.
module overlap_tag_pipe #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tag_i,
  input  logic                 last_i,
  input  logic [BIT_WIDTH-1:0] data_i,
  output logic                 valid_o,
  output logic                 last_o,
  output logic [BIT_WIDTH-1:0] data_o,
  output logic                 pending_o
);

  logic [1:0]           tag_sr_q, tag_sr_d;
  logic [1:0]           last_sr_q, last_sr_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [BIT_WIDTH-1:0] data_q, data_d;

  // The third stage captures buffer data only for tagged slots so m_data stays 0 between outputs
  always_comb begin
    tag_sr_d  = {tag_sr_q[0], tag_i};
    last_sr_d = {last_sr_q[0], last_i & tag_i};
    valid_d   = tag_sr_q[1];
    last_d    = last_sr_q[1];
    data_d    = tag_sr_q[1] ? data_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_sr_q  <= '0;
      last_sr_q <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      tag_sr_q  <= tag_sr_d;
      last_sr_q <= last_sr_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign last_o    = last_q;
  assign data_o    = data_q;
  assign pending_o = |tag_sr_q;

endmodule

// File: rtl/overlap_seq_ctrl.sv
// Row sequencer: feeds partial products into an external overlap-add buffer and
// emits each completed output sample once its last contributing tap is written.
module overlap_seq_ctrl
  import overlap_pkg::*;
#(
  parameter int BIT_WIDTH    = 8,
  parameter int INPUT_WIDTH  = 5,
  parameter int KERNEL_WIDTH = 5,
  parameter int STRIDE       = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  overlap_seq_ctrl_if.master bus,
  output logic               busy_o,
  output logic               done_o
);

  localparam int OUT_LEN      = out_len(INPUT_WIDTH, KERNEL_WIDTH, STRIDE);
  localparam int FLUSH_GROUPS = flush_groups(KERNEL_WIDTH, STRIDE);
  localparam int TAP_W        = cnt_width(KERNEL_WIDTH);
  localparam int PIX_W        = cnt_width((INPUT_WIDTH > FLUSH_GROUPS) ? INPUT_WIDTH : FLUSH_GROUPS);
  localparam int EMIT_W       = cnt_width(OUT_LEN + 1);

  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(KERNEL_WIDTH - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(INPUT_WIDTH - 1);
  localparam logic [PIX_W-1:0]  GRP_LAST  = PIX_W'((FLUSH_GROUPS > 0) ? FLUSH_GROUPS - 1 : 0);
  localparam logic [EMIT_W-1:0] EMIT_MAX  = EMIT_W'(OUT_LEN);
  localparam logic [EMIT_W-1:0] EMIT_LAST = EMIT_W'(OUT_LEN - 1);
  localparam state_e            FEED_EXIT = (FLUSH_GROUPS > 0) ? FLUSH : DRAIN;

  state_e               state_q, state_d;
  logic [TAP_W-1:0]     tap_cnt_q, tap_cnt_d;
  logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [EMIT_W-1:0]    emit_cnt_q, emit_cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [BIT_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                 tag_q, tag_d;
  logic                 last_q, last_d;
  logic                 issue;
  logic                 pipe_valid, pipe_last, pipe_pending;
  logic [BIT_WIDTH-1:0] pipe_data;

  always_comb begin
    state_d    = state_q;
    tap_cnt_d  = tap_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    emit_cnt_d = emit_cnt_q;
    wr_en_d    = 1'b0;
    wr_data_d  = '0;
    tag_d      = 1'b0;
    last_d     = 1'b0;
    issue      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = FEED;
          tap_cnt_d  = '0;
          pix_cnt_d  = '0;
          emit_cnt_d = '0;
        end
      end
      FEED: begin
        if (bus.s_valid_i) begin
          issue     = 1'b1;
          wr_data_d = bus.s_data_i;
          if (tap_cnt_q == TAP_LAST) begin
            tap_cnt_d = '0;
            if (pix_cnt_q == PIX_LAST) begin
              pix_cnt_d = '0;
              state_d   = FEED_EXIT;
            end else begin
              pix_cnt_d = pix_cnt_q + 1'b1;
            end
          end else begin
            tap_cnt_d = tap_cnt_q + 1'b1;
          end
        end
      end
      // pix_cnt doubles as the flush group counter; the writes carry zeros
      FLUSH: begin
        issue = 1'b1;
        if (tap_cnt_q == TAP_LAST) begin
          tap_cnt_d = '0;
          if (pix_cnt_q == GRP_LAST) begin
            pix_cnt_d = '0;
            state_d   = DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end else begin
          tap_cnt_d = tap_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!tag_q && !pipe_pending) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A tap below STRIDE is the final contribution to its output sample
    if (issue) begin
      wr_en_d = 1'b1;
      tag_d   = (int'(tap_cnt_q) < STRIDE) && (emit_cnt_q < EMIT_MAX);
      last_d  = tag_d && (emit_cnt_q == EMIT_LAST);
      if (tag_d) begin
        emit_cnt_d = emit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tap_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      emit_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      tag_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_cnt_q  <= tap_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      emit_cnt_q <= emit_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      tag_q      <= tag_d;
      last_q     <= last_d;
    end
  end

  overlap_tag_pipe #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_tag_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tag_i    (tag_q),
    .last_i   (last_q),
    .data_i   (bus.buf_data_i),
    .valid_o  (pipe_valid),
    .last_o   (pipe_last),
    .data_o   (pipe_data),
    .pending_o(pipe_pending)
  );

  assign bus.s_ready_o   = (state_q == FEED);
  assign bus.buf_wr_en_o = wr_en_q;
  assign bus.buf_data_o  = wr_data_q;
  assign bus.m_valid_o   = pipe_valid;
  assign bus.m_last_o    = pipe_last;
  assign bus.m_data_o    = pipe_data;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = pipe_last;

endmodule

// File: tb/tb_overlap_seq_ctrl.sv
// Randomized scoreboard bench for overlap_seq_ctrl with an ideal overlap-add buffer model.
module tb_overlap_seq_ctrl;

  localparam int N_PIX   = 5;
  localparam int K_TAPS  = 5;
  localparam int STR     = 2;
  localparam int BEATS   = N_PIX * K_TAPS;
  localparam int OUT_N   = (N_PIX - 1) * STR + K_TAPS;
  localparam int FLUSH_N = ((K_TAPS - STR) + STR - 1) / STR;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  exp_t exp_q[$];
  int   lat_q[$];

  int accept_idx;
  int row_wr;
  int flush_wr;
  int flush_bad;
  int row_out;
  int row_done;

  overlap_seq_ctrl_if #(.BIT_WIDTH(8)) bus ();

  overlap_seq_ctrl #(
    .BIT_WIDTH   (8),
    .INPUT_WIDTH (N_PIX),
    .KERNEL_WIDTH(K_TAPS),
    .STRIDE      (STR)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .bus    (bus),
    .busy_o (busy),
    .done_o (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Ideal overlap-add buffer: write n lands at position STR*(n/K)+(n%K); its running sum is read back two edges later
  int         acc[64];
  int         buf_wr_cnt;
  int         buf_pos;
  logic [7:0] rd1, rd2;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) acc[i] = 0;
      buf_wr_cnt = 0;
      rd1 <= '0;
      rd2 <= '0;
    end else begin
      if (start && !busy) begin
        for (int i = 0; i < 64; i++) acc[i] = 0;
        buf_wr_cnt = 0;
      end
      rd2 <= rd1;
      if (bus.buf_wr_en_o) begin
        buf_pos      = STR * (buf_wr_cnt / K_TAPS) + (buf_wr_cnt % K_TAPS);
        acc[buf_pos] = (acc[buf_pos] + int'(bus.buf_data_o)) % 256;
        rd1         <= 8'(acc[buf_pos]);
        buf_wr_cnt++;
      end
    end
  end

  assign bus.buf_data_i = rd2;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Monitor: counts per-row activity and pops the scoreboard whenever the DUT presents an output
  always @(negedge clk) begin
    exp_t e;
    int   due;
    if (start && !busy && !rst) begin
      accept_idx = 0;
      row_wr     = 0;
      flush_wr   = 0;
      flush_bad  = 0;
      row_out    = 0;
      row_done   = 0;
    end
    if (!rst && bus.s_valid_i && bus.s_ready_o) begin
      if ((accept_idx % K_TAPS) < STR) lat_q.push_back(cycle + 4);
      accept_idx++;
    end
    if (bus.buf_wr_en_o) begin
      row_wr++;
      if (row_wr > BEATS) begin
        flush_wr++;
        if (bus.buf_data_o != 8'd0) flush_bad++;
      end
    end
    if (done) row_done++;
    if (bus.m_valid_o) begin
      row_out++;
      checkOutput("output_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("m_data", int'(bus.m_data_o), e.data);
        checkOutput("m_last", int'(bus.m_last_o), int'(e.last));
        checkOutput("done_with_last", int'(done), int'(e.last));
      end
      if (lat_q.size() > 0) begin
        due = lat_q.pop_front();
        checkOutput("output_latency", cycle, due);
      end
    end else begin
      checkOutput("last_done_without_valid", int'({bus.m_last_o, done}), 0);
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, int'({bus.s_ready_o, busy, bus.buf_wr_en_o, bus.m_valid_o, bus.m_last_o, done}), 0);
    checkOutput({tag, "_buf_data"}, int'(bus.buf_data_o), 0);
    checkOutput({tag, "_m_data"}, int'(bus.m_data_o), 0);
  endtask

  // mode: 0 = always valid, 1 = valid every other cycle, 2 = random valid
  task automatic applyStimulus(input int mode, input bit ones, input bit restart_mid, input int abort_after);
    int   beat_data[BEATS];
    int   golden[OUT_N];
    int   sum;
    int   idx;
    int   guard;
    int   target;
    bit   v;
    bit   rdy;
    bit   tog;
    bit   mid_sent;
    exp_t e;

    golden = '{1, 1, 2, 2, 3, 2, 3, 2, 3, 2, 2, 1, 1};
    for (int b = 0; b < BEATS; b++) beat_data[b] = ones ? 1 : int'($urandom_range(0, 80));

    // Output p is the sum of every tap t of pixel i with STR*i + t == p
    for (int p = 0; p < OUT_N; p++) begin
      sum = 0;
      for (int i = 0; i < N_PIX; i++)
        for (int t = 0; t < K_TAPS; t++)
          if (STR * i + t == p) sum += beat_data[i * K_TAPS + t];
      e.data = ones ? golden[p] : (sum % 256);
      e.last = (p == OUT_N - 1);
      exp_q.push_back(e);
    end

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    target   = (abort_after >= 0) ? abort_after : BEATS;
    idx      = 0;
    guard    = 0;
    tog      = 1'b0;
    mid_sent = 1'b0;
    while (idx < target && guard < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.s_valid_i = v;
      bus.s_data_i  = 8'(beat_data[idx]);
      if (restart_mid && idx == 7 && !mid_sent) begin
        start    = 1'b1;
        mid_sent = 1'b1;
      end
      rdy = bus.s_ready_o;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (v && rdy) idx++;
      guard++;
    end
    bus.s_valid_i = 1'b0;
    checkOutput("feed_complete", idx, target);

    if (abort_after >= 0) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      lat_q.delete();
      checkIdleOutputs("abort");
      repeat (10) @(posedge clk);
      #1;
      checkOutput("aborted_row_done", row_done, 0);
      checkOutput("aborted_busy", int'(busy), 0);
    end else begin
      guard = 0;
      while ((busy || exp_q.size() != 0) && guard < 400) begin
        @(posedge clk);
        #1;
        guard++;
      end
      checkOutput("row_finished", int'(guard < 400), 1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("row_outputs", row_out, OUT_N);
      checkOutput("row_done_pulses", row_done, 1);
      checkOutput("flush_writes", flush_wr, FLUSH_N * K_TAPS);
      checkOutput("flush_nonzero", flush_bad, 0);
      checkOutput("total_writes", row_wr, BEATS + FLUSH_N * K_TAPS);
      checkOutput("idle_after_row", int'({busy, bus.s_ready_o, bus.buf_wr_en_o}), 0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkIdleOutputs("reset");

    $display("[TB] valid beats before start");
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 8'h55;
    repeat (4) begin
      checkOutput("pre_start_ready", int'(bus.s_ready_o), 0);
      @(posedge clk);
      #1;
      checkOutput("pre_start_write", int'(bus.buf_wr_en_o), 0);
    end
    bus.s_valid_i = 1'b0;

    $display("[TB] all-ones row, no stalls");
    applyStimulus(0, 1'b1, 1'b0, -1);
    $display("[TB] all-ones row, valid every other cycle");
    applyStimulus(1, 1'b1, 1'b0, -1);
    $display("[TB] random row with a second start pulse mid-feed");
    applyStimulus(1, 1'b0, 1'b1, -1);
    $display("[TB] row aborted by reset after 12 beats");
    applyStimulus(0, 1'b0, 1'b0, 12);
    $display("[TB] random row after abort");
    applyStimulus(0, 1'b0, 1'b0, -1);
    $display("[TB] random rows with random stalls");
    for (int r = 0; r < 3; r++) applyStimulus(2, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
